// File: rtl/symbol_sequencer.sv
// rtl/symbol_sequencer.sv - memory-game sequencer: shows a growing random symbol
// sequence, then checks the player's replay of it one entry at a time.
module symbol_sequencer #(
    parameter int         MAX_LEN    = 16,
    parameter int         SHOW_TICKS = 30,
    parameter int         GAP_TICKS  = 15,
    parameter logic [9:0] X0         = 10'd304,
    parameter logic [9:0] Y0         = 10'd224
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [2:0] btn_sym,
    output logic [2:0] value,
    output logic [9:0] top_left_x,
    output logic [9:0] top_left_y,
    output logic       sym_en,
    output logic [4:0] level,
    output logic       fail,
    output logic       win
);
    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, GEN, SHOW, GAP, WAIT_IN, ECHO, FAIL, WIN} state_t;

    state_t         state, state_n;
    logic [4:0]     len, len_n, idx, idx_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [15:0]    lfsr;
    logic [2:0]     value_n;
    logic           sym_en_n, fail_n, win_n, mem_we;
    logic [1:0]     shown;
    logic [1:0]     mem [MAX_LEN];

    assign top_left_x = X0;
    assign top_left_y = Y0;
    assign level      = len;

    always_comb begin
        state_n  = state;
        len_n    = len;
        idx_n    = idx;
        cnt_n    = cnt;
        fail_n   = fail;
        win_n    = win;
        mem_we   = 1'b0;
        case (state)
            IDLE, FAIL, WIN: begin
                if (start) begin
                    len_n   = 5'd0;
                    fail_n  = 1'b0;
                    win_n   = 1'b0;
                    state_n = GEN;
                end
            end
            GEN: begin
                mem_we  = 1'b1;
                len_n   = len + 5'd1;
                idx_n   = 5'd0;
                cnt_n   = '0;
                state_n = SHOW;
            end
            SHOW: begin
                if (tick) begin
                    if (cnt == CW'(SHOW_TICKS - 1)) begin
                        cnt_n   = '0;
                        state_n = GAP;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt == CW'(GAP_TICKS - 1)) begin
                        cnt_n = '0;
                        if (idx == len - 5'd1) begin
                            idx_n   = 5'd0;
                            state_n = WAIT_IN;
                        end else begin
                            idx_n   = idx + 5'd1;
                            state_n = SHOW;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            WAIT_IN: begin
                if (btn_valid) begin
                    if (btn_sym == {1'b0, mem[idx[IW-1:0]]}) begin
                        state_n = ECHO;
                    end else begin
                        state_n = FAIL;
                        fail_n  = 1'b1;
                    end
                end
            end
            ECHO: begin
                if (tick) begin
                    if (cnt == CW'(SHOW_TICKS - 1)) begin
                        cnt_n = '0;
                        if (idx < len - 5'd1) begin
                            idx_n   = idx + 5'd1;
                            state_n = WAIT_IN;
                        end else if (len == 5'(MAX_LEN)) begin
                            state_n = WIN;
                            win_n   = 1'b1;
                        end else begin
                            state_n = GEN;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // The symbol being written this cycle is not in mem yet, so bypass it.
        shown = (mem_we && idx_n == len) ? lfsr[1:0] : mem[idx_n[IW-1:0]];

        sym_en_n = (state_n == SHOW) || (state_n == ECHO) || (state_n == FAIL);
        value_n  = 3'd4;
        if (state_n == SHOW) begin
            value_n = {1'b0, shown};
        end else if (state_n == ECHO) begin
            value_n = (state == ECHO) ? value : btn_sym;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            len    <= 5'd0;
            idx    <= 5'd0;
            cnt    <= '0;
            lfsr   <= 16'hACE1;
            value  <= 3'd4;
            sym_en <= 1'b0;
            fail   <= 1'b0;
            win    <= 1'b0;
        end else begin
            state  <= state_n;
            len    <= len_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            value  <= value_n;
            sym_en <= sym_en_n;
            fail   <= fail_n;
            win    <= win_n;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[len[IW-1:0]] <= lfsr[1:0];
        end
    end
endmodule

// File: tb/tb_symbol_sequencer.sv
// tb/tb_symbol_sequencer.sv - scoreboard bench: a game-level model predicts every
// displayed symbol, echo, fail and win; a monitor pops and compares.
module tb_symbol_sequencer;
    localparam int MAXL = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       btn_valid = 1'b0;
    logic [2:0] btn_sym = 3'd0;
    logic [2:0] value;
    logic [9:0] top_left_x, top_left_y;
    logic       sym_en;
    logic [4:0] level;
    logic       fail, win;

    symbol_sequencer #(
        .MAX_LEN(MAXL), .SHOW_TICKS(2), .GAP_TICKS(1), .X0(10'd304), .Y0(10'd224)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .btn_valid(btn_valid), .btn_sym(btn_sym), .value(value),
        .top_left_x(top_left_x), .top_left_y(top_left_y), .sym_en(sym_en),
        .level(level), .fail(fail), .win(win)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0 display (show or echo), 1 fail, 2 win
        logic [2:0] value;
        logic [4:0] level;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] seq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         tcyc  = 0;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference random source: the seed advanced once per clock since reset.
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcyc = tcyc + 1;
            tick = (tcyc % 4 == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic push_exp(input int kind, input logic [2:0] v, input int lvl);
        exp_t e;
        e.kind  = kind;
        e.value = v;
        e.level = 5'(lvl);
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: kind %0d value %0d level %0d, nothing expected", kind, value, level);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_value", value, e.value);
            check("event_level", level, e.level);
            if (kind != 0) check("event_sym_en", sym_en, (kind == 1) ? 1 : 0);
        end
    endtask

    initial begin
        bit p_sym, p_fail, p_win;
        int tcount;
        p_sym = 0; p_fail = 0; p_win = 0; tcount = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                p_sym = 0; p_fail = 0; p_win = 0; tcount = 0;
            end else begin
                if (p_sym && !sym_en && !p_fail) check("pulse_ticks", tcount, 2);
                if (fail && !p_fail)                take(1);
                else if (win && !p_win)             take(2);
                else if (sym_en && !p_sym) begin
                    take(0);
                    tcount = 0;
                end
                if (sym_en && !fail && tick) tcount++;
                p_sym = sym_en; p_fail = fail; p_win = win;
            end
        end
    end

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            if (tick) c++;
        end
    endtask

    task automatic pulse_btn(input logic [2:0] s, input bit with_start);
        @(negedge clk);
        btn_valid = 1'b1;
        btn_sym   = s;
        start     = with_start;
        @(negedge clk);
        btn_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        seq.delete();
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called during the GEN cycle: the new symbol is the low bits of the current seed.
    task automatic gen_capture(input int lvl);
        @(negedge clk);
        seq.push_back(m_lfsr[1:0]);
        for (int j = 0; j < lvl; j++) push_exp(0, {1'b0, seq[j]}, lvl);
        @(negedge clk);
        check("level_after_gen", level, lvl);
    endtask

    task automatic play_level(input int lvl, input bit inject, input bit make_fail);
        logic [2:0] wrong;
        gen_capture(lvl);
        if (inject) begin
            wait_ticks(1);
            pulse_btn(3'($urandom_range(0, 7)), 1'b1);
            wait_ticks(1);
            pulse_btn(3'($urandom_range(0, 7)), 1'b0);
            check("level_after_show_noise", level, lvl);
            wait_ticks(3 * lvl - 2);
        end else begin
            wait_ticks(3 * lvl);
        end
        for (int i = 0; i < lvl; i++) begin
            if (make_fail && i == 0) begin
                do wrong = 3'($urandom_range(0, 7)); while (wrong == {1'b0, seq[0]});
                push_exp(1, 3'd4, lvl);
                pulse_btn(wrong, 1'b0);
                check("fail_next_clk", fail, 1);
                check("fail_sym_en", sym_en, 1);
                check("fail_value", value, 4);
                return;
            end
            push_exp(0, {1'b0, seq[i]}, lvl);
            if (i == lvl - 1 && lvl == MAXL) push_exp(2, 3'd4, lvl);
            pulse_btn({1'b0, seq[i]}, 1'b0);
            if (inject && i == 0) begin
                wait_ticks(1);
                pulse_btn(3'($urandom_range(0, 7)), 1'b0);
                check("level_after_echo_noise", level, lvl);
                wait_ticks(1);
            end else begin
                wait_ticks(2);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, value, 4);
        check({tag, "_sym_en"}, sym_en, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_win"}, win, 0);
        check({tag, "_x"}, top_left_x, 304);
        check({tag, "_y"}, top_left_y, 224);
    endtask

    initial begin
        #100000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: bench still running at t=%0t, want done", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_reset_outputs("idle");

        // Game 1: clear level 1, then miss at level 2.
        do_start();
        play_level(1, 1'b0, 1'b0);
        play_level(2, 1'b0, 1'b1);

        // Game 2: restart from FAIL and play to a win with ignored inputs at level 2.
        do_start();
        check("fail_cleared", fail, 0);
        play_level(1, 1'b0, 1'b0);
        play_level(2, 1'b1, 1'b0);
        play_level(3, 1'b0, 1'b0);
        @(negedge clk);
        check("win_flag", win, 1);
        check("win_sym_en", sym_en, 0);
        check("win_value", value, 4);
        check("win_level", level, MAXL);

        // Game 3: asynchronous reset in the middle of a level-2 echo.
        do_start();
        play_level(1, 1'b0, 1'b0);
        gen_capture(2);
        wait_ticks(6);
        push_exp(0, {1'b0, seq[0]}, 2);
        pulse_btn({1'b0, seq[0]}, 1'b0);
        wait_ticks(1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);

        // Game 4: start on the first edge after reset release.
        seq.delete();
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        play_level(1, 1'b0, 1'b0);
        gen_capture(2);
        wait_ticks(6);
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
